// File: rtl/player_missile.sv
// player_missile: player-shot controller, clocked once per frame on vsync.
// Launches one missile on a fire press, climbs SPEED px per frame, tests
// against the live enemy grid and reports a kill for exactly one frame.
//
// Ports:
//   vsync         frame clock (rising edge)
//   reset         synchronous, active-high
//   fire          fire button level, already synchronous to vsync
//   playerX       player sprite left X (sprite is 32 px wide)
//   enemy_status  alive bits [column][row]
//   enemy_offset  left X of enemy column 0
//   state         game state, 1 = playing
//   exists        missile in flight / drawn
//   missileX/Y    missile position
//   explode       explosion being shown
//   kill          one-frame kill pulse, with kill_col / kill_row
module player_missile #(
  parameter int SPEED    = 8,
  parameter int START_Y  = 440,
  parameter int HIT_HOLD = 8,
  parameter int COOLDOWN = 15
) (
  input  logic            vsync,
  input  logic            reset,
  input  logic            fire,
  input  logic [9:0]      playerX,
  input  logic [9:0][5:0] enemy_status,
  input  logic [9:0]      enemy_offset,
  input  logic [3:0]      state,
  output logic            exists,
  output logic [9:0]      missileX,
  output logic [9:0]      missileY,
  output logic            explode,
  output logic            kill,
  output logic [3:0]      kill_col,
  output logic [2:0]      kill_row
);

  typedef enum logic [1:0] {S_IDLE, S_FLY, S_HIT} st_t;

  st_t        r_st, w_st;
  logic       r_fire_lo;          // fire was low last frame; cleared by reset so a held button cannot fire
  logic [7:0] r_cool, w_cool;
  logic [7:0] r_hold, w_hold;
  logic       r_exists, w_exists;
  logic [9:0] r_mx, w_mx, r_my, w_my;
  logic       r_explode, w_explode;
  logic       r_kill, w_kill;
  logic [3:0] r_kcol, w_kcol;
  logic [2:0] r_krow, w_krow;

  // Hit test on the registered position against this frame's grid.
  logic [10:0] w_dx;
  logic [9:0]  w_dy;
  logic [3:0]  w_col;
  logic [2:0]  w_row;
  logic        w_in_y, w_alive, w_hit, w_fire_edge;

  assign w_dx   = {1'b0, r_mx} - {1'b0, enemy_offset};
  assign w_col  = w_dx[9:6];
  assign w_dy   = r_my - 10'd32;
  assign w_row  = w_dy[7:5];
  assign w_in_y = (r_my >= 10'd32) && (r_my <= 10'd223);

  always_comb begin
    w_alive = 1'b0;
    if (w_col <= 4'd9 && w_in_y) w_alive = enemy_status[w_col][w_row];
  end

  // dx[10] set means the missile is left of column 0; dx[5] set is the sprite gap.
  assign w_hit       = !w_dx[10] && (w_col <= 4'd9) && !w_dx[5] && w_in_y && w_alive;
  assign w_fire_edge = fire & r_fire_lo;

  always_comb begin
    w_st      = r_st;
    w_cool    = r_cool;
    w_hold    = r_hold;
    w_exists  = r_exists;
    w_mx      = r_mx;
    w_my      = r_my;
    w_explode = r_explode;
    w_kill    = 1'b0;
    w_kcol    = r_kcol;
    w_krow    = r_krow;
    case (r_st)
      S_IDLE: begin
        w_exists = 1'b0;
        if (r_cool != 8'd0) w_cool = r_cool - 8'd1;
        if (w_fire_edge && r_cool == 8'd0) begin
          w_mx     = playerX + 10'd16;
          w_my     = 10'(START_Y);
          w_exists = 1'b1;
          w_st     = S_FLY;
        end
      end
      S_FLY: begin
        if (w_hit) begin
          // position stays at the hit point for the explosion sprite
          w_kill    = 1'b1;
          w_kcol    = w_col;
          w_krow    = w_row;
          w_exists  = 1'b0;
          w_explode = 1'b1;
          w_hold    = 8'(HIT_HOLD);
          w_st      = S_HIT;
        end else if (r_my < 10'(SPEED)) begin
          w_exists = 1'b0;
          w_cool   = 8'(COOLDOWN);
          w_st     = S_IDLE;
        end else begin
          w_my = r_my - 10'(SPEED);
        end
      end
      S_HIT: begin
        // the hit frame itself counts as the first explosion frame
        if (r_hold <= 8'd1) begin
          w_hold    = 8'd0;
          w_explode = 1'b0;
          w_cool    = 8'(COOLDOWN);
          w_st      = S_IDLE;
        end else begin
          w_hold = r_hold - 8'd1;
        end
      end
      default: w_st = S_IDLE;
    endcase
  end

  always_ff @(posedge vsync) begin
    if (reset || state != 4'd1) begin
      r_st      <= S_IDLE;
      r_cool    <= 8'd0;
      r_hold    <= 8'd0;
      r_exists  <= 1'b0;
      r_mx      <= 10'd0;
      r_my      <= 10'd0;
      r_explode <= 1'b0;
      r_kill    <= 1'b0;
      r_kcol    <= 4'd0;
      r_krow    <= 3'd0;
      // leaving play keeps tracking the button; only a real reset forgets it
      r_fire_lo <= reset ? 1'b0 : !fire;
    end else begin
      r_st      <= w_st;
      r_cool    <= w_cool;
      r_hold    <= w_hold;
      r_exists  <= w_exists;
      r_mx      <= w_mx;
      r_my      <= w_my;
      r_explode <= w_explode;
      r_kill    <= w_kill;
      r_kcol    <= w_kcol;
      r_krow    <= w_krow;
      r_fire_lo <= !fire;
    end
  end

  assign exists   = r_exists;
  assign missileX = r_mx;
  assign missileY = r_my;
  assign explode  = r_explode;
  assign kill     = r_kill;
  assign kill_col = r_kcol;
  assign kill_row = r_krow;

endmodule

// File: tb/tb_player_missile.sv
module tb_player_missile;
  logic            vsync, reset, fire;
  logic [9:0]      playerX, enemy_offset;
  logic [9:0][5:0] enemy_status;
  logic [3:0]      state;
  logic            exists, explode, kill;
  logic [9:0]      missileX, missileY;
  logic [3:0]      kill_col;
  logic [2:0]      kill_row;

  int total = 0;
  int bad   = 0;
  logic [6:0] exp_q[$];   // expected {col,row} kill reports

  player_missile dut (
    .vsync(vsync), .reset(reset), .fire(fire), .playerX(playerX),
    .enemy_status(enemy_status), .enemy_offset(enemy_offset), .state(state),
    .exists(exists), .missileX(missileX), .missileY(missileY), .explode(explode),
    .kill(kill), .kill_col(kill_col), .kill_row(kill_row)
  );

  initial vsync = 1'b0;
  always #5 vsync = ~vsync;

  // One frame; any kill pulse is matched against the scoreboard.
  task automatic tick();
    logic [6:0] e;
    @(posedge vsync); #1;
    if (kill === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_kill got col=%0d row=%0d want none", kill_col, kill_row);
      end else begin
        e = exp_q.pop_front();
        if ({kill_col, kill_row} !== e) begin
          bad++;
          $display("FAIL kill_pos got col=%0d row=%0d want col=%0d row=%0d",
                   kill_col, kill_row, e[6:3], e[2:0]);
        end
      end
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1; fire = 1'b0; state = 4'd1;
    ticks(2);
    reset = 1'b0;
  endtask

  task automatic launch(input logic [9:0] px);
    playerX = px;
    fire = 1'b0; tick();
    fire = 1'b1; tick();
    fire = 1'b0;
  endtask

  // Frames until exists drops, bounded.
  task automatic fly_out(output int n);
    n = 0;
    while (exists === 1'b1 && n < 100) begin tick(); n++; end
  endtask

  task automatic test_reset();
    reset = 1'b1; fire = 1'b1; state = 4'd1; playerX = 10'd100;
    enemy_status = '0; enemy_offset = '0;
    ticks(2);
    total++;
    if ({exists, explode, kill, missileX, missileY, kill_col, kill_row} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got ex=%b exp=%b k=%b x=%0d y=%0d c=%0d r=%0d want all 0",
               exists, explode, kill, missileX, missileY, kill_col, kill_row);
    end
    reset = 1'b0;
    ticks(3);
    total++;
    if (exists !== 1'b0) begin bad++; $display("FAIL held_fire_after_reset got exists=%b want 0", exists); end
    fire = 1'b0; tick(); fire = 1'b1; tick(); fire = 1'b0;
    total++;
    if (exists !== 1'b1 || missileX !== 10'd116) begin
      bad++; $display("FAIL rearm_launch got exists=%b x=%0d want 1 x=116", exists, missileX);
    end
  endtask

  task automatic test_launch_climb();
    int n;
    do_reset(); enemy_status = '0;
    launch(10'd100);
    total++;
    if (exists !== 1'b1 || missileX !== 10'd116 || missileY !== 10'd440) begin
      bad++; $display("FAIL launch got ex=%b x=%0d y=%0d want 1 116 440", exists, missileX, missileY);
    end
    tick();
    total++;
    if (missileY !== 10'd432) begin bad++; $display("FAIL first_move got y=%0d want 432", missileY); end
    fly_out(n);
    total++;
    if (n !== 55 || missileY !== 10'd0) begin
      bad++; $display("FAIL climb_exit got frames=%0d y=%0d want 55 y=0", n, missileY);
    end
  endtask

  task automatic test_hit();
    int cnt;
    do_reset();
    enemy_offset = '0; enemy_status = '0; enemy_status[2][5] = 1'b1;
    exp_q.push_back({4'd2, 3'd5});
    launch(10'd128);
    ticks(28);
    total++;
    if (missileY !== 10'd216 || exists !== 1'b1 || kill !== 1'b0) begin
      bad++; $display("FAIL pre_hit got y=%0d ex=%b k=%b want 216 1 0", missileY, exists, kill);
    end
    tick();
    total++;
    if (kill !== 1'b1 || explode !== 1'b1 || exists !== 1'b0 || missileX !== 10'd144 || missileY !== 10'd216) begin
      bad++; $display("FAIL hit_frame got k=%b exp=%b ex=%b x=%0d y=%0d want 1 1 0 144 216",
                      kill, explode, exists, missileX, missileY);
    end
    cnt = 1;
    while (explode === 1'b1 && cnt < 50) begin
      tick();
      if (explode === 1'b1) cnt++;
      if (kill !== 1'b0) begin bad++; total++; $display("FAIL kill_width got kill=%b want 0", kill); end
    end
    total++;
    if (cnt !== 8) begin bad++; $display("FAIL explode_frames got %0d want 8", cnt); end
    // cooldown = 15 now; an edge on the 15th frame is still too early
    ticks(14);
    fire = 1'b1; tick();
    total++;
    if (exists !== 1'b0) begin bad++; $display("FAIL cooldown_edge got exists=%b want 0", exists); end
    fire = 1'b0; tick(); fire = 1'b1; tick(); fire = 1'b0;
    total++;
    if (exists !== 1'b1) begin bad++; $display("FAIL post_cooldown_launch got exists=%b want 1", exists); end
  endtask

  task automatic test_gap_and_offset();
    int n;
    do_reset();
    enemy_offset = '0; enemy_status = '0; enemy_status[2][5] = 1'b1;
    launch(10'd160);
    total++;
    if (missileX !== 10'd176) begin bad++; $display("FAIL gap_x got %0d want 176", missileX); end
    fly_out(n);
    total++;
    if (n !== 56) begin bad++; $display("FAIL gap_miss got frames=%0d want 56", n); end
    do_reset();
    enemy_status = '1; enemy_offset = 10'd200;
    launch(10'd134);
    fly_out(n);
    total++;
    if (n !== 56 || missileX !== 10'd150) begin
      bad++; $display("FAIL neg_dx got frames=%0d x=%0d want 56 150", n, missileX);
    end
    do_reset();
    enemy_offset = '0;
    launch(10'd624);
    fly_out(n);
    total++;
    if (n !== 56) begin bad++; $display("FAIL col10 got frames=%0d want 56", n); end
  endtask

  task automatic test_edge_cases();
    do_reset(); enemy_status = '0; enemy_offset = '0;
    launch(10'd300);
    ticks(3);
    fire = 1'b0; tick(); fire = 1'b1; tick(); fire = 1'b0;
    total++;
    if (exists !== 1'b1 || missileY !== 10'd400) begin
      bad++; $display("FAIL fire_in_flight got ex=%b y=%0d want 1 400", exists, missileY);
    end
    state = 4'd2; tick();
    total++;
    if (exists !== 1'b0 || missileY !== 10'd0 || missileX !== 10'd0) begin
      bad++; $display("FAIL not_playing got ex=%b x=%0d y=%0d want 0 0 0", exists, missileX, missileY);
    end
    state = 4'd1; ticks(3);
    total++;
    if (exists !== 1'b0) begin bad++; $display("FAIL resume_idle got exists=%b want 0", exists); end
    // pending hit overridden by reset on the same edge
    do_reset(); enemy_status[2][5] = 1'b1;
    launch(10'd128);
    ticks(28);
    reset = 1'b1; tick(); reset = 1'b0;
    total++;
    if (kill !== 1'b0 || explode !== 1'b0) begin
      bad++; $display("FAIL reset_over_hit got k=%b exp=%b want 0 0", kill, explode);
    end
    // leave play mid-explosion: silent
    do_reset();
    exp_q.push_back({4'd2, 3'd5});
    launch(10'd128);
    ticks(29);
    state = 4'd2; tick(); state = 4'd1;
    total++;
    if (explode !== 1'b0 || kill !== 1'b0) begin
      bad++; $display("FAIL stop_mid_explode got exp=%b k=%b want 0 0", explode, kill);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    do_reset(); enemy_status = '0;
    launch(10'd50);
    fly_out(n);
    // edge during cooldown, then held high: nothing queued
    fire = 1'b1; ticks(5);
    total++;
    if (exists !== 1'b0) begin bad++; $display("FAIL held_in_cooldown got exists=%b want 0", exists); end
    fire = 1'b0; ticks(9);   // cooldown reaches 0 on the 15th frame after exit
    fire = 1'b1; tick();     // 15th frame: cooldown was 1, edge discarded
    total++;
    if (exists !== 1'b0) begin bad++; $display("FAIL early_relaunch got exists=%b want 0", exists); end
    fire = 1'b0; tick();
    fire = 1'b1; tick(); fire = 1'b0;
    total++;
    if (exists !== 1'b1 || missileX !== 10'd66 || missileY !== 10'd440) begin
      bad++; $display("FAIL relaunch got ex=%b x=%0d y=%0d want 1 66 440", exists, missileX, missileY);
    end
  endtask

  initial begin
    reset = 1'b1; fire = 1'b0; state = 4'd1; playerX = '0;
    enemy_status = '0; enemy_offset = '0;
    test_reset();
    test_launch_climb();
    test_hit();
    test_gap_and_offset();
    test_edge_cases();
    test_back_to_back();
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL missing_kill got pending=%0d want 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/player_missile.md
# player_missile

Player-shot controller for the game core, the upward counterpart of the enemy missile. It launches one missile from the player cannon on a fire press and moves it up one step per frame. It tests the missile against the live enemy grid and emits a single-frame kill report (column and row) that the enemy-array owner uses to clear the `enemy_status` bit. It runs on the frame clock next to the enemy missile and feeds the renderer and the score logic.

## Interface
Parameters:
- `SPEED`, 8: pixels the missile moves up per frame.
- `START_Y`, 440: missile Y at launch.
- `HIT_HOLD`, 8: frames the explosion is shown after a kill.
- `COOLDOWN`, 15: frames after a missile ends before the next launch is allowed.

Ports:
- `vsync`, in, 1: frame clock, rising edge. One clock and one reset only; reset is synchronous and active-high.
- `reset`, in, 1: synchronous, active-high.
- `fire`, in, 1: fire button, level, already synchronised to `vsync`.
- `playerX`, in, 10: player left X; the player sprite is 32 px wide.
- `enemy_status`, in, [9:0][5:0]: alive bits, indexed [column][row].
- `enemy_offset`, in, 10: left X of enemy column 0.
- `state`, in, 4: game state; 1 = playing.
- `exists`, out, 1: missile is in flight and drawn.
- `missileX`, out, 10: missile X.
- `missileY`, out, 10: missile Y.
- `explode`, out, 1: high while the explosion is held.
- `kill`, out, 1: one-frame pulse when an enemy is hit.
- `kill_col`, out, 4: column of the hit enemy; valid while `kill` is high.
- `kill_row`, out, 3: row of the hit enemy; valid while `kill` is high.

## Operation
- **Reset values**: state IDLE; `exists`=0, `explode`=0, `kill`=0; `missileX`=0, `missileY`=0, `kill_col`=0, `kill_row`=0; cooldown counter=0; fire history=0.
- **Fire edge**: a launch needs a 0→1 edge of `fire`, sampled frame to frame. Holding `fire` gives one shot only.
- **Grid geometry**:
  - Column c spans X from `enemy_offset`+64c to `enemy_offset`+64c+31. This is the sprite area; bits [5:0] of dx must be < 32.
  - Row r spans Y from 32+32r to 63+32r, r in 0..5.
- **Hit test** (combinational on the current `missileX`/`missileY`):
  - dx = `missileX` − `enemy_offset`, computed at 11 bits; no hit if the result is negative.
  - col = dx[9:6]; require col ≤ 9 and dx[5:0] < 32.
  - Require 32 ≤ `missileY` ≤ 223; row = (`missileY` − 32) >> 5.
  - Hit = all of the above and `enemy_status`[col][row] = 1.
- **States**:
  - **IDLE**: `exists`=0. On a fire edge with cooldown=0:
    - `missileX` = `playerX` + 16, truncated to 10 bits.
    - `missileY` = `START_Y`.
    - `exists`=1, go to FLY.
  - **FLY**, evaluated once per frame in this priority order:
    1. Hit: `kill`=1 for this frame, latch `kill_col`/`kill_row`, `exists`=0, `explode`=1, load the hold counter with `HIT_HOLD`, go to HIT. `missileX`/`missileY` are frozen at the hit point so the explosion can be drawn.
    2. `missileY` < `SPEED`: `exists`=0, load cooldown with `COOLDOWN`, go to IDLE. This is a miss off the top, so `missileY` never underflows.
    3. Otherwise `missileY` −= `SPEED`.
  - **HIT**: `explode`=1; decrement the hold counter. When it reaches 0: `explode`=0, load cooldown with `COOLDOWN`, go to IDLE.
  - **Cooldown**: the counter decrements every frame in IDLE while nonzero. A fire edge while cooldown > 0 is discarded; it is not queued.
- **Game not playing** (`state` ≠ 1): behaves like reset on that frame, except the fire history still updates. Leaving play mid-flight or mid-explosion is therefore silent: no `kill` pulse.
- Fire edges during FLY or HIT are ignored.
- `enemy_status` may change on any frame. The test always uses the value sampled on the current edge. A kill on an enemy the owner has already cleared cannot occur.

## Timing
- **Launch**: fire edge seen at edge N → `exists`=1, `missileY`=`START_Y` after edge N. The first move happens at N+1.
- **Hit**: the hit is detected on the edge after the missile reaches the hit position. `kill` is high for exactly one frame. `explode` rises on that same edge.
- **Kill consumer**: `enemy_status` shows the clear at the earliest one frame later.
- **Hold**: `explode` stays high for `HIT_HOLD` frames, then cooldown runs for `COOLDOWN` frames.
- **Earliest relaunch**: on the edge after cooldown reaches 0.
- All outputs are registered. There is no combinational path from inputs to outputs.
- **Reset priority**: `reset` overrides everything on the same edge, including a pending hit.

## Test plan
- **Reset**: reset held 2 frames → all outputs 0, state IDLE; `fire` high through reset → no launch until `fire` goes low then high again.
- **Launch and climb**: `playerX`=100, fire edge → `missileX`=116, `missileY`=440. Next frame `missileY`=432. With an empty grid the missile is removed after reaching Y=0; `kill` never asserts.
- **Hit**: `enemy_offset`=0, only [2][5] alive, `playerX`=128 → `missileX`=144 (dx[5:0]=16). At `missileY`=216:
  - `kill`=1 for one frame, `kill_col`=2, `kill_row`=5;
  - `explode` high for 8 frames, then 15 frames of cooldown.
- **Gap miss**: same grid, `playerX`=160 → `missileX`=176 (dx[5:0]=48, sprite gap) → no kill, exits at top.
- **Offset boundary**: `enemy_offset`=200, `missileX`=150 → no hit despite row overlap (negative dx); column index 10+ never hits.
- **Edge cases**:
  - Fire edge during flight and during cooldown → ignored, no queued launch.
  - `state` forced to 2 mid-flight → `exists`=0 next frame, no `kill`.
